// File: rtl/ddmtd_phase_core.sv
// DDMTD phase detector core: synchronises and deglitches two beat inputs, timestamps
// rising edges against a free-running counter and reports A->B phase and A->A period.
module ddmtd_phase_core #(
  parameter int CNT_W = 16,
  parameter int DG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_a,
  input  logic             in_b,
  input  logic [DG_W-1:0]  dg_thresh,
  input  logic             clr,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [CNT_W-1:0] phase,
  output logic [CNT_W-1:0] period,
  output logic             overrun,
  output logic             timeout,
  output logic             busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARM     = 2'd1;
  localparam logic [1:0] WAIT_B  = 2'd2;
  localparam logic [1:0] WAIT_A2 = 2'd3;

  logic [1:0]      raw;
  logic [1:0]      pulse;
  logic [DG_W-1:0] thr;

  assign raw = {in_b, in_a};
  assign thr = (dg_thresh == '0) ? DG_W'(1) : dg_thresh;

  // Channel 0 is A, channel 1 is B; identical paths keep the latency equal on both.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic            sync1_reg;
      logic            sync2_reg;
      logic            st_reg;
      logic            rise_reg;
      logic [DG_W-1:0] dc_reg;
      logic            dc_hit;

      assign dc_hit = (({1'b0, dc_reg} + (DG_W+1)'(1)) == {1'b0, thr});

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          st_reg    <= 1'b0;
          rise_reg  <= 1'b0;
          dc_reg    <= '0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          rise_reg  <= 1'b0;
          if (sync2_reg == st_reg) begin
            dc_reg <= '0;
          end else if (dc_hit) begin
            st_reg   <= sync2_reg;
            rise_reg <= sync2_reg;
            dc_reg   <= '0;
          end else begin
            dc_reg <= dc_reg + 1'b1;
          end
        end
      end

      assign pulse[gi] = rise_reg;
    end
  endgenerate

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] ts_reg;
  logic [CNT_W-1:0] ta_reg, ta_next;
  logic [CNT_W-1:0] ph_acc_reg, ph_acc_next;
  logic [CNT_W-1:0] phase_reg, phase_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic             valid_reg, valid_next;
  logic             overrun_reg, overrun_next;
  logic             timeout_reg, timeout_next;
  logic [CNT_W-1:0] elapsed;
  logic             at_limit;
  logic             a_p, b_p;
  logic             done, load, set_ov, set_to;

  assign a_p      = pulse[0];
  assign b_p      = pulse[1];
  assign elapsed  = ts_reg - ta_reg;
  assign at_limit = (elapsed == '1);

  always_comb begin
    state_next  = state_reg;
    ta_next     = ta_reg;
    ph_acc_next = ph_acc_reg;
    done        = 1'b0;
    set_to      = 1'b0;
    if (!ena) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          // Arming restarts the reference so the ARM watchdog counts from here.
          state_next = ARM;
          ta_next    = ts_reg;
        end
        ARM: begin
          if (a_p) begin
            ta_next = ts_reg;
            if (b_p) begin
              ph_acc_next = '0;
              state_next  = WAIT_A2;
            end else begin
              state_next = WAIT_B;
            end
          end else if (at_limit) begin
            set_to  = 1'b1;
            ta_next = ts_reg;
          end
        end
        WAIT_B: begin
          if (b_p) begin
            ph_acc_next = a_p ? '0 : elapsed;
            if (a_p) ta_next = ts_reg;
            state_next = WAIT_A2;
          end else if (a_p) begin
            ta_next = ts_reg;
          end else if (at_limit) begin
            set_to     = 1'b1;
            ta_next    = ts_reg;
            state_next = ARM;
          end
        end
        default: begin
          if (a_p) begin
            done       = 1'b1;
            ta_next    = ts_reg;
            state_next = WAIT_B;
          end else if (at_limit) begin
            set_to     = 1'b1;
            ta_next    = ts_reg;
            state_next = ARM;
          end
        end
      endcase
    end

    load         = done && (!valid_reg || res_ready);
    set_ov       = done && !load;
    valid_next   = load | (valid_reg & ~res_ready);
    phase_next   = load ? ph_acc_reg : phase_reg;
    period_next  = load ? elapsed : period_reg;
    // A new event outranks a clear arriving in the same cycle.
    overrun_next = set_ov | (overrun_reg & ~clr);
    timeout_next = set_to | (timeout_reg & ~clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ts_reg      <= '0;
      ta_reg      <= '0;
      ph_acc_reg  <= '0;
      phase_reg   <= '0;
      period_reg  <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ts_reg      <= ts_reg + 1'b1;
      ta_reg      <= ta_next;
      ph_acc_reg  <= ph_acc_next;
      phase_reg   <= phase_next;
      period_reg  <= period_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
      timeout_reg <= timeout_next;
    end
  end

  assign res_valid = valid_reg;
  assign phase     = phase_reg;
  assign period    = period_reg;
  assign overrun   = overrun_reg;
  assign timeout   = timeout_reg;
  assign busy      = (state_reg != IDLE);

endmodule
